// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with registered reads.
// Entry 0 is hardwired to zero. Write-port collisions resolve with port 0 highest.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data into rdata.
module regfile_mp #(
    parameter int DW      = 32,
    parameter int NREGS   = 32,
    parameter int AW      = $clog2(NREGS),
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int RET_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic              stall,
    output logic [DW-1:0]     ret_val
);

    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_mp: NRD must be in 1..4");
    end
    if (NWR < 1 || NWR > 4) begin : g_bad_nwr
        $error("regfile_mp: NWR must be in 1..4");
    end
    if (RET_REG < 0 || RET_REG >= NREGS) begin : g_bad_ret
        $error("regfile_mp: RET_REG must be below NREGS");
    end

    localparam logic [AW-1:0] RET_IDX = AW'(RET_REG);

    logic [DW-1:0]     mem_q [NREGS];
    logic [DW-1:0]     mem_d [NREGS];
    logic [NRD*DW-1:0] rdata_q;
    logic [NRD*DW-1:0] rdata_d;

    // Merge all write ports into the next array image; ports are applied from
    // the highest index down so port 0 is applied last and wins collisions.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned j = NWR; j > 0; j--) begin
            if (wen[j-1] && (waddr[(j-1)*AW +: AW] != '0)) begin
                mem_d[waddr[(j-1)*AW +: AW]] = wdata[(j-1)*DW +: DW];
            end
        end
        mem_d[0] = '0;
    end

    // Next read data: hold under stall, otherwise look up (and optionally forward).
    always_comb begin
        rdata_d = rdata_q;
        if (!stall) begin
            for (int unsigned i = 0; i < NRD; i++) begin
                rdata_d[i*DW +: DW] = mem_q[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned j = NWR; j > 0; j--) begin
                    if (wen[j-1] && (waddr[(j-1)*AW +: AW] == raddr[i*AW +: AW])) begin
                        rdata_d[i*DW +: DW] = wdata[(j-1)*DW +: DW];
                    end
                end
`endif
                // Address 0 always reads zero, which also excludes it from forwarding.
                if (raddr[i*AW +: AW] == '0) begin
                    rdata_d[i*DW +: DW] = '0;
                end
            end
        end
    end

    // Array and read-data registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign ret_val = mem_q[RET_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (2R/2W, 32x32, RET_REG=6).
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] EXP_SAME_R6  = 32'h0000_0099;
    localparam logic [31:0] EXP_SAME_R10 = 32'h0000_00A0;
`else
    localparam logic [31:0] EXP_SAME_R6  = 32'h0000_0001;
    localparam logic [31:0] EXP_SAME_R10 = 32'h0000_0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] waddr;
    logic [NWR*DW-1:0] wdata;
    logic              stall;
    logic [DW-1:0]     ret_val;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .DW(DW), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .RET_REG(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .wen(wen),
        .waddr(waddr), .wdata(wdata), .stall(stall), .ret_val(ret_val)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1);
        wen   = en;
        waddr = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic drive_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0;
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd0, 5'd0);
        step(); step();
        checks++;
        if (rdata !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 64'h0);
        end
        checks++;
        if (ret_val !== 32'h0) begin
            errors++; $display("FAIL reset_ret_val: got %h want %h", ret_val, 32'h0);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        drive_wr(2'b10, 5'd0, 32'h0, 5'd7, 32'h1234_5678);
        drive_rd(5'd0, 5'd0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd7, 5'd7);
        step();
        checks++;
        if (rdata[31:0] !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_rd_port0: got %h want %h", rdata[31:0], 32'h1234_5678);
        end
        checks++;
        if (rdata[63:32] !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_rd_port1: got %h want %h", rdata[63:32], 32'h1234_5678);
        end
    endtask

    task automatic test_collision();
        // Both ports to r3: port 0 wins.
        drive_wr(2'b11, 5'd3, 32'hAAAA_0000, 5'd3, 32'h5555_FFFF);
        step();
        // Non-colliding ports commit together.
        drive_wr(2'b11, 5'd8, 32'h0000_0088, 5'd4, 32'h0000_0044);
        step();
        // Disabled port 0 must not block port 1.
        drive_wr(2'b10, 5'd9, 32'hDEAD_0009, 5'd9, 32'h0000_0009);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd3, 5'd4);
        step();
        checks++;
        if (rdata[31:0] !== 32'hAAAA_0000) begin
            errors++; $display("FAIL collision_r3: got %h want %h", rdata[31:0], 32'hAAAA_0000);
        end
        checks++;
        if (rdata[63:32] !== 32'h0000_0044) begin
            errors++; $display("FAIL collision_r4: got %h want %h", rdata[63:32], 32'h0000_0044);
        end
        drive_rd(5'd8, 5'd9);
        step();
        checks++;
        if (rdata[31:0] !== 32'h0000_0088) begin
            errors++; $display("FAIL noncollide_r8: got %h want %h", rdata[31:0], 32'h0000_0088);
        end
        checks++;
        if (rdata[63:32] !== 32'h0000_0009) begin
            errors++; $display("FAIL port1_only_r9: got %h want %h", rdata[63:32], 32'h0000_0009);
        end
    endtask

    task automatic test_zero_reg();
        // rdata currently non-zero; write r0 and read r0 in the same cycle.
        drive_wr(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
        drive_rd(5'd0, 5'd0);
        step();
        checks++;
        if (rdata !== 64'h0) begin
            errors++; $display("FAIL zero_same_cycle: got %h want %h", rdata, 64'h0);
        end
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        checks++;
        if (rdata !== 64'h0) begin
            errors++; $display("FAIL zero_after_write: got %h want %h", rdata, 64'h0);
        end
    endtask

    task automatic test_stall();
        drive_wr(2'b01, 5'd2, 32'h0000_0011, 5'd0, 32'h0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd2, 5'd8);
        step();
        checks++;
        if (rdata[31:0] !== 32'h0000_0011) begin
            errors++; $display("FAIL stall_pre: got %h want %h", rdata[31:0], 32'h0000_0011);
        end
        stall = 1'b1;
        drive_wr(2'b01, 5'd2, 32'h0000_0022, 5'd0, 32'h0);
        drive_rd(5'd9, 5'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rdata !== {32'h0000_0088, 32'h0000_0011}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got %h want %h", i, rdata,
                         {32'h0000_0088, 32'h0000_0011});
            end
        end
        stall = 1'b0;
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd2, 5'd4);
        step();
        checks++;
        if (rdata[31:0] !== 32'h0000_0022) begin
            errors++; $display("FAIL stall_release: got %h want %h", rdata[31:0], 32'h0000_0022);
        end
    endtask

    task automatic test_same_cycle();
        drive_wr(2'b01, 5'd6, 32'h0000_0001, 5'd0, 32'h0);
        step();
        checks++;
        if (ret_val !== 32'h0000_0001) begin
            errors++; $display("FAIL ret_val_r6_init: got %h want %h", ret_val, 32'h0000_0001);
        end
        drive_wr(2'b01, 5'd6, 32'h0000_0099, 5'd0, 32'h0);
        drive_rd(5'd6, 5'd0);
        step();
        checks++;
        if (rdata[31:0] !== EXP_SAME_R6) begin
            errors++; $display("FAIL same_cycle_r6: got %h want %h", rdata[31:0], EXP_SAME_R6);
        end
        checks++;
        if (ret_val !== 32'h0000_0099) begin
            errors++; $display("FAIL ret_val_r6: got %h want %h", ret_val, 32'h0000_0099);
        end
        // Colliding writes to r10 with a same-cycle read: forwarding must pick port 0.
        drive_wr(2'b11, 5'd10, 32'h0000_00A0, 5'd10, 32'h0000_00B0);
        drive_rd(5'd0, 5'd10);
        step();
        checks++;
        if (rdata[63:32] !== EXP_SAME_R10) begin
            errors++; $display("FAIL same_cycle_r10: got %h want %h", rdata[63:32], EXP_SAME_R10);
        end
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        checks++;
        if (rdata[63:32] !== 32'h0000_00A0) begin
            errors++; $display("FAIL r10_after: got %h want %h", rdata[63:32], 32'h0000_00A0);
        end
    endtask

    task automatic test_reset_mid();
        drive_wr(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
        drive_rd(5'd0, 5'd0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd5, 5'd6);
        step();
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL pre_reset_r5: got %h want %h", rdata[31:0], 32'hDEAD_BEEF);
        end
        // Assert reset between edges: the clear must happen without a clock edge.
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++; $display("FAIL async_clear_rdata: got %h want %h", rdata, 64'h0);
        end
        checks++;
        if (ret_val !== 32'h0) begin
            errors++; $display("FAIL async_clear_ret_val: got %h want %h", ret_val, 32'h0);
        end
        // Writes attempted during reset must be ignored.
        drive_wr(2'b11, 5'd5, 32'h5555_5555, 5'd6, 32'h6666_6666);
        step(); step(); step();
        rst_n = 1'b1;
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd5, 5'd6);
        step();
        checks++;
        if (rdata !== 64'h0) begin
            errors++; $display("FAIL post_reset_rdata: got %h want %h", rdata, 64'h0);
        end
        checks++;
        if (ret_val !== 32'h0) begin
            errors++; $display("FAIL post_reset_ret_val: got %h want %h", ret_val, 32'h0);
        end
        // First edge after release behaves normally.
        drive_wr(2'b10, 5'd0, 32'h0, 5'd5, 32'h0000_0055);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        checks++;
        if (rdata[31:0] !== 32'h0000_0055) begin
            errors++; $display("FAIL post_reset_write: got %h want %h", rdata[31:0], 32'h0000_0055);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_stall();
        test_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
